// File: rtl/dec_arb_pkg.sv
// Shared types and constants for the decoder round-robin arbiter.
package dec_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // {G1, G2a_n, G2b_n}: only G1 high with both active-low enables low turns the decoder on
    localparam logic [2:0] DEC_EN_ON  = 3'b100;
    localparam logic [2:0] DEC_EN_OFF = 3'b000;

endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick over 8 requesters: rotate so last+1 is bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] last,
    output logic       found,
    output logic [2:0] winner
);

    logic [7:0] rot;
    logic [2:0] start;
    logic [2:0] off;

    always_comb begin
        start = last + 3'd1;
        rot   = '0;
        for (int i = 0; i < 8; i++) begin
            rot[i] = req[3'(start + 3'(i))];
        end
        found = |rot;
        off   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot[i]) off = 3'(i);
        end
        winner = start + off;
    end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin owner of a 3-to-8 decoder's enable/select lines, with a
// break-before-make gap between grants and a bounded grant tenure.
module dec_rr_arbiter
    import dec_arb_pkg::*;
#(
    parameter int MAX_HOLD   = 15,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] dec_en,
    output logic [2:0] dec_in,
    output logic       grant_valid,
    output logic [2:0] grant_id
);

    arb_state_e state_q, state_d;
    logic [2:0] dec_en_q, dec_en_d;
    logic [2:0] dec_in_q, dec_in_d;
    logic       grant_valid_q, grant_valid_d;
    logic [2:0] grant_id_q, grant_id_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gap_q, gap_d;

    logic       pick_found;
    logic [2:0] pick_winner;
    logic       release_grant;

    rr_pick8 u_pick (
        .req    (req),
        .last   (last_q),
        .found  (pick_found),
        .winner (pick_winner)
    );

    assign release_grant = done || !req[grant_id_q] || (hold_q == 8'(MAX_HOLD - 1));

    always_comb begin
        state_d       = state_q;
        dec_en_d      = dec_en_q;
        dec_in_d      = dec_in_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        last_d        = last_q;
        hold_d        = hold_q;
        gap_d         = gap_q;

        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d       = GRANT;
                    dec_en_d      = DEC_EN_ON;
                    dec_in_d      = pick_winner;
                    grant_id_d    = pick_winner;
                    grant_valid_d = 1'b1;
                    hold_d        = 8'd0;
                end
            end
            GRANT: begin
                hold_d = hold_q + 8'd1;
                if (release_grant) begin
                    state_d       = GAP;
                    dec_en_d      = DEC_EN_OFF;
                    grant_valid_d = 1'b0;
                    last_d        = grant_id_q;
                    gap_d         = 4'd0;
                end
            end
            GAP: begin
                // Select lines stay put while disabled; the last gap cycle arbitrates
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    if (pick_found) begin
                        state_d       = GRANT;
                        dec_en_d      = DEC_EN_ON;
                        dec_in_d      = pick_winner;
                        grant_id_d    = pick_winner;
                        grant_valid_d = 1'b1;
                        hold_d        = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d       = IDLE;
                dec_en_d      = DEC_EN_OFF;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dec_en_q      <= DEC_EN_OFF;
            dec_in_q      <= 3'd0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= 3'd0;
            last_q        <= 3'd7;
            hold_q        <= 8'd0;
            gap_q         <= 4'd0;
        end else begin
            state_q       <= state_d;
            dec_en_q      <= dec_en_d;
            dec_in_q      <= dec_in_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            last_q        <= last_d;
            hold_q        <= hold_d;
            gap_q         <= gap_d;
        end
    end

    assign dec_en      = dec_en_q;
    assign dec_in      = dec_in_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;

endmodule
